prbs22_checker: RTL and testbench

- Receive-side counterpart of the 22-bit PRBS generator (taps 21, 14, 13, 7).
- Takes the serial bit stream, self-synchronises a local copy of the sequence, and declares lock.
- Once locked, flags and counts every bit error.
- Sits at the output of the channel/DSP chain under test and provides BER measurement.

---
 rtl/prbs22_checker.sv | 149 ++++++++++++++
 tb/tb_prbs22_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/prbs22_checker.sv
// Self-synchronising checker for the 22-bit PRBS (taps 21,14,13,7): SEARCH -> VERIFY -> LOCKED, with BER counters.
// err_pulse lags the sampled bit by one cycle; counters saturate; clk_en low freezes everything (err_pulse forced 0).
module prbs22_checker #(
    parameter int unsigned LOCK_CNT    = 64,
    parameter int unsigned WIN         = 1024,
    parameter int unsigned LOSS_THRESH = 128,
    parameter int unsigned ERR_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clk_en_i,
    input  logic             rx_bit_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_pulse_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [ERR_W-1:0] bit_count_o
);
    localparam logic [1:0]       S_SEARCH   = 2'd0;
    localparam logic [1:0]       S_VERIFY   = 2'd1;
    localparam logic [1:0]       S_LOCKED   = 2'd2;
    localparam logic [4:0]       FILL_FULL  = 5'd22;
    localparam logic [15:0]      LOCK_CNT_C = 16'(LOCK_CNT);
    localparam logic [15:0]      WIN_LAST   = 16'(WIN - 1);
    localparam logic [16:0]      THRESH_C   = 17'(LOSS_THRESH);
    localparam logic [ERR_W-1:0] CNT_MAX    = '1;
    localparam logic [ERR_W-1:0] CNT_ONE    = ERR_W'(1);

    logic [1:0]       state_q, state_d;
    logic [21:0]      shadow_q, shadow_d;
    logic [4:0]       fill_q, fill_d;
    logic [15:0]      match_q, match_d;
    logic [15:0]      win_cnt_q, win_cnt_d;
    logic [15:0]      win_err_q, win_err_d;
    logic             locked_q;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0] bit_cnt_q, bit_cnt_d;

    logic        pred;
    logic        bit_err;
    logic [21:0] shift_rx;
    logic [16:0] win_err_inc;

    assign pred        = shadow_q[21] ^ shadow_q[14] ^ shadow_q[13] ^ shadow_q[7];
    assign bit_err     = rx_bit_i ^ pred;
    assign shift_rx    = {shadow_q[20:0], rx_bit_i};
    assign win_err_inc = {1'b0, win_err_q} + {16'd0, bit_err};

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        err_pulse_d = 1'b0;
        if (clk_en_i) begin
            case (state_q)
                S_SEARCH: begin
                    shadow_d = shift_rx;
                    fill_d   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 5'd1;
                    // An all-zero shadow is the LFSR lock-up state, so never leave SEARCH on it.
                    if (fill_d == FILL_FULL && shift_rx != '0) begin
                        state_d = S_VERIFY;
                        match_d = '0;
                    end
                end
                S_VERIFY: begin
                    shadow_d = shift_rx;
                    if (shift_rx == '0) begin
                        state_d = S_SEARCH;
                        fill_d  = '0;
                        match_d = '0;
                    end else if (!bit_err) begin
                        match_d = match_q + 16'd1;
                        if (match_d == LOCK_CNT_C) begin
                            state_d   = S_LOCKED;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                S_LOCKED: begin
                    // Free-running shadow: a corrupted rx bit never pollutes later predictions.
                    shadow_d    = {shadow_q[20:0], pred};
                    err_pulse_d = bit_err;
                    if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_ONE;
                    if (bit_err && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
                    if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if (win_err_inc >= THRESH_C) begin
                            state_d = S_SEARCH;
                            fill_d  = '0;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 16'd1;
                        win_err_d = win_err_inc[15:0];
                    end
                end
                default: begin
                    state_d = S_SEARCH;
                    fill_d  = '0;
                end
            endcase
        end
        if (clear_i) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_SEARCH;
            shadow_q    <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= (state_d == S_LOCKED);
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked_o    = locked_q;
    assign err_pulse_o = err_pulse_q;
    assign err_count_o = err_cnt_q;
    assign bit_count_o = bit_cnt_q;

endmodule

// File: tb/tb_prbs22_checker.sv
// Bench for prbs22_checker: reference PRBS22 generator drives the DUT, err_pulse checked through a scoreboard queue.
module tb_prbs22_checker;
    localparam int ERR_W = 32;

    logic             clk_i    = 1'b0;
    logic             rst_ni   = 1'b0;
    logic             clk_en_i = 1'b0;
    logic             rx_bit_i = 1'b0;
    logic             clear_i  = 1'b0;
    logic             locked_o;
    logic             err_pulse_o;
    logic [ERR_W-1:0] err_count_o;
    logic [ERR_W-1:0] bit_count_o;

    prbs22_checker #(
        .LOCK_CNT   (64),
        .WIN        (1024),
        .LOSS_THRESH(128),
        .ERR_W      (ERR_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clk_en_i   (clk_en_i),
        .rx_bit_i   (rx_bit_i),
        .clear_i    (clear_i),
        .locked_o   (locked_o),
        .err_pulse_o(err_pulse_o),
        .err_count_o(err_count_o),
        .bit_count_o(bit_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic en;
        logic inj;
        logic clr;
        logic pulse;
        int   err;
        int   bits;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [21:0] gen_q;
    logic       exp_q[$];
    int         win_pos = 0;
    logic       force_zero = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic next_bit(output logic b);
        b     = gen_q[0];
        gen_q = {gen_q[20:0], gen_q[21] ^ gen_q[14] ^ gen_q[13] ^ gen_q[7]};
    endtask

    // Called at posedge+1; drives one cycle and scoreboards the err_pulse it should produce.
    task automatic send(input logic en, input logic inj, input logic clr, input logic exp_pulse);
        logic b;
        b = 1'b0;
        if (en) next_bit(b);
        clk_en_i = en;
        rx_bit_i = force_zero ? 1'b0 : (b ^ inj);
        clear_i  = clr;
        exp_q.push_back(exp_pulse);
        @(posedge clk_i);
        #1;
        if (en) win_pos++;
        check("err_pulse", err_pulse_o, exp_q.pop_front());
    endtask

    task automatic wait_lock(input int period, output int nbits, output int nclk);
        nbits = 0;
        nclk  = 0;
        while (!locked_o && nclk < 2000) begin
            nclk++;
            if (nclk % period == 0) begin
                nbits++;
                send(1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                send(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        win_pos = 0;
    endtask

    task automatic sync_reset();
        clk_en_i = 1'b0;
        clear_i  = 1'b0;
        rst_ni   = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    vec_t tbl[10];
    int   nb, nc;
    logic seen, early_drop;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 2};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 2};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 3};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 4};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 3, 5};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 6};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1};

        gen_q = '1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_locked", locked_o, 0);
        check("rst_err_pulse", err_pulse_o, 0);
        check("rst_err_count", err_count_o, 0);
        check("rst_bit_count", bit_count_o, 0);
        rst_ni = 1'b1;

        // Acquire lock on a clean stream.
        wait_lock(1, nb, nc);
        check("lock_bits", nb, 86);
        check("lock_err_count", err_count_o, 0);
        check("lock_bit_count", bit_count_o, 0);
        repeat (10) send(1'b1, 1'b0, 1'b0, 1'b0);
        check("bit_count_10", bit_count_o, 10);

        foreach (tbl[i]) begin
            send(tbl[i].en, tbl[i].inj, tbl[i].clr, tbl[i].pulse);
            check($sformatf("tbl%0d_err_count", i), err_count_o, tbl[i].err);
            check($sformatf("tbl%0d_bit_count", i), bit_count_o, tbl[i].bits);
        end
        check("tbl_locked", locked_o, 1);

        // 128 errored bits in the window, then loss exactly at window close.
        send(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (128) send(1'b1, 1'b1, 1'b0, 1'b1);
        early_drop = 1'b0;
        while (win_pos < 1023) begin
            send(1'b1, 1'b0, 1'b0, 1'b0);
            if (!locked_o) early_drop = 1'b1;
        end
        check("no_early_loss", early_drop, 0);
        send(1'b1, 1'b0, 1'b0, 1'b0);
        check("loss_at_window_close", locked_o, 0);
        check("loss_err_count", err_count_o, 128);
        check("loss_bit_count", bit_count_o, 1004);
        wait_lock(1, nb, nc);
        check("relock_bits", nb, 86);

        // Short asynchronous reset pulse while locked with err_pulse high.
        send(1'b1, 1'b1, 1'b0, 1'b1);
        clk_en_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("async_locked", locked_o, 0);
        check("async_err_pulse", err_pulse_o, 0);
        check("async_err_count", err_count_o, 0);
        check("async_bit_count", bit_count_o, 0);
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        gen_q = '1;
        wait_lock(1, nb, nc);
        check("post_reset_lock_bits", nb, 86);

        // All-zero stream must never lock.
        sync_reset();
        force_zero = 1'b1;
        seen = 1'b0;
        repeat (1000) begin
            send(1'b1, 1'b0, 1'b0, 1'b0);
            if (locked_o) seen = 1'b1;
        end
        check("zero_never_locked", seen, 0);
        check("zero_err_count", err_count_o, 0);
        check("zero_bit_count", bit_count_o, 0);
        force_zero = 1'b0;

        // 1-in-3 enable, then clear colliding with an error.
        sync_reset();
        gen_q = '1;
        wait_lock(3, nb, nc);
        check("en3_lock_clocks", nc, 258);
        check("en3_lock_bits", nb, 86);
        send(1'b1, 1'b1, 1'b0, 1'b1);
        check("en3_err_count", err_count_o, 1);
        check("en3_bit_count", bit_count_o, 1);
        send(1'b1, 1'b1, 1'b1, 1'b1);
        check("clear_err_count", err_count_o, 0);
        check("clear_bit_count", bit_count_o, 0);
        check("clear_locked", locked_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
